// File: rtl/vmul_pkg.sv
// Shared types and constants for the vector multiplier operand path.
package vmul_pkg;

  localparam int BYTE_W = 8;
  localparam int PP_W   = 16;
  localparam int N_MUL  = 8;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10
  } sew_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    PH1,
    PH2,
    DONE,
    ERR
  } pp_state_e;

  function automatic logic [BYTE_W-1:0] byte_of(input logic [4*BYTE_W-1:0] w,
                                                input logic [1:0]          idx);
    return w[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/mul_8x8_u.sv
// Unsigned 8x8 -> 16 combinational multiplier.
module mul_8x8_u
  import vmul_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [PP_W-1:0]   p
);

  assign p = {8'b0, a} * {8'b0, b};

endmodule

// File: rtl/pp_issue_seq.sv
// Operand sequencer for the vector multiplier: latches an operand pair and issues
// 8x8 partial products to carry_save_8 in one phase (8b/16b) or two phases (32b).
//
//  state | meaning
//  IDLE  | waiting for an operand pair, in_ready high
//  ISSUE | cs_start to the accumulator
//  PH1   | first set of partial products on mult_out
//  PH2   | 32b only: products of b2/b3, added at weight 2^16 downstream
//  DONE  | accumulator result valid, done pulse
//  ERR   | sew=11 rejected, err pulse, accumulator untouched
module pp_issue_seq #(
  parameter int DATA_W = 32,
  parameter int PP_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sew,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              cs_start,
  output logic [1:0]        cs_sew,
  output logic [PP_W-1:0]   mult_out_1,
  output logic [PP_W-1:0]   mult_out_2,
  output logic [PP_W-1:0]   mult_out_3,
  output logic [PP_W-1:0]   mult_out_4,
  output logic [PP_W-1:0]   mult_out_5,
  output logic [PP_W-1:0]   mult_out_6,
  output logic [PP_W-1:0]   mult_out_7,
  output logic [PP_W-1:0]   mult_out_8,
  output logic              done,
  output logic              err
);

  import vmul_pkg::*;

  pp_state_e         state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q;
  sew_e              sew_q;
  logic              accept;

  logic [BYTE_W-1:0] mul_a [N_MUL];
  logic [BYTE_W-1:0] mul_b [N_MUL];
  logic [PP_W-1:0]   mul_p [N_MUL];

  assign in_ready = reset && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign cs_sew   = sew_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // An illegal sew leaves sew_q untouched so cs_sew never carries 2'b11.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      sew_q <= SEW_8;
    end else if (accept) begin
      a_q <= operand_a;
      b_q <= operand_b;
      if (sew != 2'b11) sew_q <= sew_e'(sew);
    end
  end

  always_comb begin
    state_nxt = state;
    cs_start  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = (sew == 2'b11) ? ERR : ISSUE;
      ISSUE: begin
        cs_start  = 1'b1;
        state_nxt = PH1;
      end
      PH1:     state_nxt = (sew_q == SEW_32) ? PH2 : DONE;
      PH2:     state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte routing per lane width; zero operands outside the product phases force mult_out to 0.
  always_comb begin
    for (int k = 0; k < N_MUL; k++) begin
      mul_a[k] = '0;
      mul_b[k] = '0;
    end
    if (state == PH1 || state == PH2) begin
      for (int k = 0; k < N_MUL; k++) begin
        case (sew_q)
          SEW_8: begin
            if (k < 4) begin
              mul_a[k] = byte_of(a_q, k[1:0]);
              mul_b[k] = byte_of(b_q, k[1:0]);
            end
          end
          SEW_16: begin
            mul_a[k] = byte_of(a_q, {k[2], k[0]});
            mul_b[k] = byte_of(b_q, {k[2], k[1]});
          end
          SEW_32: begin
            mul_a[k] = byte_of(a_q, k[1:0]);
            mul_b[k] = byte_of(b_q, {state == PH2, k[2]});
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_MUL; g++) begin : g_mul
    mul_8x8_u u_mul (
      .a (mul_a[g]),
      .b (mul_b[g]),
      .p (mul_p[g])
    );
  end

  assign mult_out_1 = mul_p[0];
  assign mult_out_2 = mul_p[1];
  assign mult_out_3 = mul_p[2];
  assign mult_out_4 = mul_p[3];
  assign mult_out_5 = mul_p[4];
  assign mult_out_6 = mul_p[5];
  assign mult_out_7 = mul_p[6];
  assign mult_out_8 = mul_p[7];

endmodule

// File: tb/tb_pp_issue_seq.sv
// Bench for pp_issue_seq: per-cycle timing checks, partial products against lane
// arithmetic, and accumulated results against full-width lane products.
module tb_pp_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sew;
  logic [31:0] operand_a, operand_b;
  logic        cs_start;
  logic [1:0]  cs_sew;
  logic [15:0] mult_out_1, mult_out_2, mult_out_3, mult_out_4;
  logic [15:0] mult_out_5, mult_out_6, mult_out_7, mult_out_8;
  logic        done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] nxt_a, nxt_b;
  logic [1:0]  nxt_s;

  logic [15:0] mo [8];
  assign mo[0] = mult_out_1;
  assign mo[1] = mult_out_2;
  assign mo[2] = mult_out_3;
  assign mo[3] = mult_out_4;
  assign mo[4] = mult_out_5;
  assign mo[5] = mult_out_6;
  assign mo[6] = mult_out_7;
  assign mo[7] = mult_out_8;

  always #5 clk = ~clk;

  pp_issue_seq #(.DATA_W(32), .PP_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sew        (sew),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .cs_start   (cs_start),
    .cs_sew     (cs_sew),
    .mult_out_1 (mult_out_1),
    .mult_out_2 (mult_out_2),
    .mult_out_3 (mult_out_3),
    .mult_out_4 (mult_out_4),
    .mult_out_5 (mult_out_5),
    .mult_out_6 (mult_out_6),
    .mult_out_7 (mult_out_7),
    .mult_out_8 (mult_out_8),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [15:0] bm(input logic [31:0] a, input logic [31:0] b,
                                     input int i, input int j);
    logic [15:0] x, y;
    x = {8'b0, a[8*i +: 8]};
    y = {8'b0, b[8*j +: 8]};
    return x * y;
  endfunction

  // Partial product expected on multiplier k (0..7) in phase ph (0/1).
  function automatic logic [15:0] exp_pp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] s, input int ph, input int k);
    case (s)
      2'b00: return (k < 4) ? bm(a, b, k, k) : 16'h0;
      2'b01: begin
        case (k)
          0: return bm(a, b, 0, 0);
          1: return bm(a, b, 1, 0);
          2: return bm(a, b, 0, 1);
          3: return bm(a, b, 1, 1);
          4: return bm(a, b, 2, 2);
          5: return bm(a, b, 3, 2);
          6: return bm(a, b, 2, 3);
          default: return bm(a, b, 3, 3);
        endcase
      end
      default: return bm(a, b, k % 4, (k / 4) + 2 * ph);
    endcase
  endfunction

  function automatic logic [15:0] mo_or();
    return mo[0] | mo[1] | mo[2] | mo[3] | mo[4] | mo[5] | mo[6] | mo[7];
  endfunction

  // Runs one operation starting just after a negedge; returns just after the negedge
  // of the first cycle in which the block is idle again.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                        input bit hold, input bit ready_now);
    int waited;
    logic [15:0] obs [2][8];
    logic [63:0] full, gold;
    logic [31:0] p1, p2, g1, g2;
    in_valid  = 1'b1;
    sew       = s;
    operand_a = a;
    operand_b = b;
    if (ready_now) check("ready_now", 64'(in_ready), 64'd1);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);  // T+1
    if (hold) begin
      operand_a = nxt_a;
      operand_b = nxt_b;
      sew       = nxt_s;
    end else begin
      in_valid  = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      sew       = 2'($urandom_range(0, 3));
    end
    check("ready_busy", 64'(in_ready), 64'd0);
    check("done_t1", 64'(done), 64'd0);
    check("pp_t1_zero", 64'(mo_or()), 64'd0);
    if (s == 2'b11) begin
      check("err_t1", 64'(err), 64'd1);
      check("start_err", 64'(cs_start), 64'd0);
      @(negedge clk);  // T+2
      check("ready_after_err", 64'(in_ready), 64'd1);
      check("err_once", 64'(err), 64'd0);
      check("no_done_err", 64'(done), 64'd0);
      check("no_start_err", 64'(cs_start), 64'd0);
      return;
    end
    check("start_t1", 64'(cs_start), 64'd1);
    check("err_t1", 64'(err), 64'd0);
    check("sew_t1", 64'(cs_sew), 64'(s));
    for (int ph = 0; ph < ((s == 2'b10) ? 2 : 1); ph++) begin
      @(negedge clk);
      check("start_ph", 64'(cs_start), 64'd0);
      check("done_ph", 64'(done), 64'd0);
      check("ready_ph", 64'(in_ready), 64'd0);
      check("sew_ph", 64'(cs_sew), 64'(s));
      for (int k = 0; k < 8; k++) begin
        obs[ph][k] = mo[k];
        check($sformatf("pp%0d_k%0d", ph + 1, k + 1), 64'(mo[k]), 64'(exp_pp(a, b, s, ph, k)));
      end
    end
    @(negedge clk);  // DONE
    check("done_pulse", 64'(done), 64'd1);
    check("ready_done", 64'(in_ready), 64'd0);
    check("pp_done_zero", 64'(mo_or()), 64'd0);
    check("sew_done", 64'(cs_sew), 64'(s));
    @(negedge clk);
    check("ready_again", 64'(in_ready), 64'd1);
    check("done_once", 64'(done), 64'd0);

    // What carry_save_8 would present, rebuilt from the observed partial products.
    case (s)
      2'b00: begin
        p1 = {obs[0][1], obs[0][0]};
        p2 = {obs[0][3], obs[0][2]};
        g1 = {16'(a[15:8]) * 16'(b[15:8]), 16'(a[7:0]) * 16'(b[7:0])};
        g2 = {16'(a[31:24]) * 16'(b[31:24]), 16'(a[23:16]) * 16'(b[23:16])};
      end
      2'b01: begin
        p1 = 32'(obs[0][0]) + (32'(obs[0][1]) << 8) + (32'(obs[0][2]) << 8) + (32'(obs[0][3]) << 16);
        p2 = 32'(obs[0][4]) + (32'(obs[0][5]) << 8) + (32'(obs[0][6]) << 8) + (32'(obs[0][7]) << 16);
        g1 = 32'(a[15:0]) * 32'(b[15:0]);
        g2 = 32'(a[31:16]) * 32'(b[31:16]);
      end
      default: begin
        full = '0;
        for (int ph = 0; ph < 2; ph++)
          for (int k = 0; k < 8; k++)
            full += 64'(obs[ph][k]) << (8 * (k % 4) + 8 * (k / 4) + 16 * ph);
        gold = 64'(a) * 64'(b);
        p1 = full[31:0];
        p2 = full[63:32];
        g1 = gold[31:0];
        g2 = gold[63:32];
      end
    endcase
    check("product_1", 64'(p1), 64'(g1));
    check("product_2", 64'(p2), 64'(g2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 64'(cs_start), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_sew"}, 64'(cs_sew), 64'd0);
    check({tag, "_pp"}, 64'(mo_or()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rs;
    reset     = 1'b0;
    in_valid  = 1'b0;
    sew       = 2'b00;
    operand_a = '0;
    operand_b = '0;
    nxt_a     = '0;
    nxt_b     = '0;
    nxt_s     = 2'b00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("ready_post_reset", 64'(in_ready), 64'd1);

    run_op(32'h04030201, 32'h08070605, 2'b00, 1'b0, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b0, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b1);
    run_op(32'h00000100, 32'h00010000, 2'b10, 1'b0, 1'b1);
    run_op(32'h12345678, 32'h9ABCDEF0, 2'b11, 1'b0, 1'b1);

    nxt_a = 32'hA1B2C3D4;
    nxt_b = 32'h11223344;
    nxt_s = 2'b00;
    run_op(32'h0F0E0D0C, 32'hF0E0D0C0, 2'b00, 1'b1, 1'b1);
    run_op(nxt_a, nxt_b, nxt_s, 1'b0, 1'b1);

    // Reset during PH1 of a 32b operation.
    in_valid  = 1'b1;
    sew       = 2'b10;
    operand_a = 32'hFFFFFFFF;
    operand_b = 32'hFFFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_in_ph1", 64'(mult_out_1), 64'h0000FE01);
    #1 reset = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_done_after", 64'(done), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    run_op(32'hDEADBEEF, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       begin ra = 32'hFFFFFFFF; rb = $urandom; end
        1:       begin ra = $urandom & 32'hFF00FF00; rb = $urandom & 32'h00FF00FF; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      rs = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, rs, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
